// File: rtl/flex_timer.sv
// Up/down counter between two programmable bounds, with prescaler, load,
// and continuous or one-shot terminal behaviour.
module flex_timer #(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     dir,
  input  logic                     one_shot,
  input  logic [NUM_CNT_BITS-1:0]  low_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse,
  output logic                     done
);

  logic [PRESCALE_BITS-1:0] presc;
  logic [PRESCALE_BITS-1:0] next_presc;
  logic [NUM_CNT_BITS-1:0]  next_count;
  logic [NUM_CNT_BITS-1:0]  terminal;
  logic [NUM_CNT_BITS-1:0]  wrap_target;
  logic [NUM_CNT_BITS-1:0]  stepped;
  logic                     tick;
  logic                     at_terminal;
  logic                     next_done;
  logic                     next_wrap;

  assign terminal    = dir ? low_val : rollover_val;
  assign wrap_target = dir ? rollover_val : low_val;
  assign tick        = count_enable && (presc == prescale_val);
  assign at_terminal = (count_out == terminal);
  assign stepped     = dir ? (count_out - 1'b1) : (count_out + 1'b1);

  always_comb begin
    next_count = count_out;
    next_presc = presc;
    next_done  = done;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = load_val;
      next_presc = '0;
      next_done  = 1'b0;
    end else begin
      if (tick) begin
        next_presc = '0;
      end else if (count_enable) begin
        next_presc = presc + 1'b1;
      end
      if (tick) begin
        if (one_shot) begin
          // Once done is set the count parks until a load or clear re-arms it.
          if (!done) begin
            if (at_terminal) begin
              next_done = 1'b1;
              next_wrap = 1'b1;
            end else begin
              next_count = stepped;
            end
          end
        end else begin
          if (at_terminal) begin
            next_count = wrap_target;
            next_wrap  = 1'b1;
          end else begin
            next_count = stepped;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out     <= '0;
      presc         <= '0;
      done          <= 1'b0;
      wrap_pulse    <= 1'b0;
      rollover_flag <= 1'b0;
    end else if (clear) begin
      count_out     <= '0;
      presc         <= '0;
      done          <= 1'b0;
      wrap_pulse    <= 1'b0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      presc         <= next_presc;
      done          <= next_done;
      wrap_pulse    <= next_wrap;
      rollover_flag <= (next_count == terminal);
    end
  end

endmodule

// File: tb/tb_flex_timer.sv
// Directed self-checking bench for flex_timer with a 4-bit count.
module tb_flex_timer;

  localparam int N = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         count_enable;
  logic         load;
  logic [N-1:0] load_val;
  logic         dir;
  logic         one_shot;
  logic [N-1:0] low_val;
  logic [N-1:0] rollover_val;
  logic [P-1:0] prescale_val;
  logic [N-1:0] count_out;
  logic         rollover_flag;
  logic         wrap_pulse;
  logic         done;

  int testCount = 0;
  int failCount = 0;

  int t1Cnt[7]   = '{1, 2, 3, 4, 5, 2, 3};
  int t1Flag[7]  = '{0, 0, 0, 0, 1, 0, 0};
  int t1Wrap[7]  = '{0, 0, 0, 0, 0, 1, 0};
  int t2Cnt[6]   = '{2, 1, 0, 0, 0, 0};
  int t2Done[6]  = '{0, 0, 0, 1, 1, 1};
  int t2Wrap[6]  = '{0, 0, 0, 1, 0, 0};
  int t6Cnt[13]  = '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 2};
  int t7Cnt[8]   = '{13, 14, 15, 0, 1, 2, 3, 12};

  flex_timer #(.NUM_CNT_BITS(N), .PRESCALE_BITS(P)) dut (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .load(load), .load_val(load_val), .dir(dir), .one_shot(one_shot),
    .low_val(low_val), .rollover_val(rollover_val), .prescale_val(prescale_val),
    .count_out(count_out), .rollover_flag(rollover_flag),
    .wrap_pulse(wrap_pulse), .done(done)
  );

  always #5 clk = ~clk;

  // Advance the given number of rising edges and settle 1ns past the last one.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; count_enable = 1'b0; load = 1'b0;
    load_val = '0; dir = 1'b0; one_shot = 1'b0; low_val = 4'd2;
    rollover_val = 4'd5; prescale_val = '0;
    #1;
    applyStimulus(2);
    checkOutput("reset count", count_out, 0);
    checkOutput("reset flag", rollover_flag, 0);
    checkOutput("reset wrap", wrap_pulse, 0);
    checkOutput("reset done", done, 0);

    // Continuous up between 2 and 5
    rst = 1'b0; clear = 1'b1;
    applyStimulus(1);
    checkOutput("clear count", count_out, 0);
    clear = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("up count %0d", i), count_out, t1Cnt[i]);
      checkOutput($sformatf("up flag %0d", i), rollover_flag, t1Flag[i]);
      checkOutput($sformatf("up wrap %0d", i), wrap_pulse, t1Wrap[i]);
    end

    // One-shot down from 3 to 0
    count_enable = 1'b0; load = 1'b1; load_val = 4'd3; dir = 1'b1;
    one_shot = 1'b1; low_val = 4'd0;
    applyStimulus(1);
    checkOutput("os load count", count_out, 3);
    checkOutput("os load done", done, 0);
    load = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("os count %0d", i), count_out, t2Cnt[i]);
      checkOutput($sformatf("os done %0d", i), done, t2Done[i]);
      checkOutput($sformatf("os wrap %0d", i), wrap_pulse, t2Wrap[i]);
    end
    checkOutput("os flag at 0", rollover_flag, 1);
    load = 1'b1; load_val = 4'd3;
    applyStimulus(1);
    checkOutput("os rearm count", count_out, 3);
    checkOutput("os rearm done", done, 0);

    // Prescaler of 3 with an enable gap
    load = 1'b0; count_enable = 1'b0; dir = 1'b0; one_shot = 1'b0;
    low_val = 4'd0; rollover_val = 4'd15; prescale_val = 4'd2; clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0; count_enable = 1'b1;
    applyStimulus(2);
    checkOutput("presc before tick", count_out, 0);
    applyStimulus(1);
    checkOutput("presc first tick", count_out, 1);
    applyStimulus(1);
    count_enable = 1'b0;
    applyStimulus(5);
    checkOutput("presc frozen", count_out, 1);
    count_enable = 1'b1;
    applyStimulus(1);
    checkOutput("presc resume 1", count_out, 1);
    applyStimulus(1);
    checkOutput("presc resume 2", count_out, 2);
    applyStimulus(2);
    checkOutput("presc resume 4", count_out, 2);
    applyStimulus(1);
    checkOutput("presc resume 5", count_out, 3);

    // Simultaneous clear/load/tick at the terminal
    prescale_val = '0; low_val = 4'd2; rollover_val = 4'd5;
    count_enable = 1'b0; load = 1'b1; load_val = 4'd5;
    applyStimulus(1);
    checkOutput("sim at term flag", rollover_flag, 1);
    clear = 1'b1; count_enable = 1'b1;
    applyStimulus(1);
    checkOutput("clr+ld+tick count", count_out, 0);
    checkOutput("clr+ld+tick flag", rollover_flag, 0);
    checkOutput("clr+ld+tick wrap", wrap_pulse, 0);
    clear = 1'b0; count_enable = 1'b0; load_val = 4'd5;
    applyStimulus(1);
    count_enable = 1'b1; load_val = 4'd7;
    applyStimulus(1);
    checkOutput("ld+tick count", count_out, 7);
    checkOutput("ld+tick wrap", wrap_pulse, 0);
    checkOutput("ld+tick flag", rollover_flag, 0);
    count_enable = 1'b0; load_val = 4'd5;
    applyStimulus(1);
    load = 1'b0; count_enable = 1'b1;
    applyStimulus(1);
    checkOutput("tick at term count", count_out, 2);
    checkOutput("tick at term wrap", wrap_pulse, 1);

    // Synchronous reset mid-count with done set
    load = 1'b1; load_val = 4'd4; one_shot = 1'b1;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(2);
    checkOutput("pre-rst done", done, 1);
    checkOutput("pre-rst count", count_out, 5);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst count", count_out, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst flag", rollover_flag, 0);
    checkOutput("rst wrap", wrap_pulse, 0);
    rst = 1'b0; one_shot = 1'b0; count_enable = 1'b0; load = 1'b1;
    applyStimulus(1);
    load = 1'b0; count_enable = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("rst glitch ignored", count_out, 5);

    // Out-of-range start above the upper bound
    load = 1'b1; load_val = 4'd9;
    applyStimulus(1);
    checkOutput("oor load", count_out, 9);
    load = 1'b0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("oor count %0d", i), count_out, t6Cnt[i]);
      checkOutput($sformatf("oor flag %0d", i), rollover_flag, (i == 11) ? 1 : 0);
      checkOutput($sformatf("oor wrap %0d", i), wrap_pulse, (i == 12) ? 1 : 0);
    end

    // Inverted bounds wrapping through zero
    low_val = 4'd12; rollover_val = 4'd3; load = 1'b1; load_val = 4'd12;
    applyStimulus(1);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("inv count %0d", i), count_out, t7Cnt[i]);
      checkOutput($sformatf("inv wrap %0d", i), wrap_pulse, (i == 7) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
